// File: rtl/chipinvaders_pkg.sv
// Shared types and constants for the chip-invaders game logic.
package chipinvaders_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OFFER
    } sched_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Galois step: shift right, fold taps in when a one falls out
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, reusable for randomised game logic.
module lfsr16
    import chipinvaders_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/alien_bomb_scheduler.sv
// Chooses when and from which alien the formation drops a bomb, and
// offers the spawn request to the bomb datapath over valid/ready.
module alien_bomb_scheduler
    import chipinvaders_pkg::*;
#(
    parameter int          NUM_ROWS        = 5,
    parameter int          NUM_COLUMNS     = 8,
    parameter int          MAX_BOMBS       = 3,
    parameter int          COOLDOWN_FRAMES = 32,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             frame_tick,
    input  logic                             enable,
    input  logic [NUM_ROWS*NUM_COLUMNS-1:0]  alive_matrix,
    input  logic [MAX_BOMBS-1:0]             bombs_active,
    output logic                             spawn_valid,
    input  logic                             spawn_ready,
    output logic [$clog2(MAX_BOMBS)-1:0]     spawn_slot,
    output logic [$clog2(NUM_COLUMNS)-1:0]   spawn_col,
    output logic [$clog2(NUM_ROWS)-1:0]      spawn_row,
    output logic                             busy
);

    localparam int SW = $clog2(MAX_BOMBS);
    localparam int CW = $clog2(NUM_COLUMNS);
    localparam int RW = $clog2(NUM_ROWS);

    localparam logic [7:0]  CD_RELOAD = 8'(COOLDOWN_FRAMES);
    localparam logic [CW:0] SCAN_LAST = (CW+1)'(NUM_COLUMNS - 1);

    function automatic logic [SW-1:0] free_slot(
        input logic [MAX_BOMBS-1:0] act
    );
        logic [SW-1:0] s;
        s = '0;
        for (int i = MAX_BOMBS - 1; i >= 0; i--) begin
            if (!act[i]) s = SW'(i);
        end
        return s;
    endfunction

    // Highest row index is nearest the player, so the last hit wins
    function automatic logic [RW-1:0] bottom_row(
        input logic [NUM_ROWS-1:0] bits
    );
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (bits[i]) r = RW'(i);
        end
        return r;
    endfunction

    sched_state_t        state;
    logic [7:0]          cooldown;
    logic [SW-1:0]       slot_q;
    logic [CW-1:0]       col_q;
    logic [CW:0]         scan_cnt;
    logic [15:0]         lfsr;
    logic [NUM_ROWS-1:0] col_bits;
    logic                launch_ok;
    logic                lfsr_unused;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:CW];

    always_comb begin
        col_bits = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            col_bits[r] = alive_matrix[r*NUM_COLUMNS + int'(col_q)];
        end
    end

    assign launch_ok = !(&bombs_active) && (|alive_matrix);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cooldown    <= CD_RELOAD;
            slot_q      <= '0;
            col_q       <= '0;
            scan_cnt    <= '0;
            spawn_valid <= 1'b0;
            spawn_slot  <= '0;
            spawn_col   <= '0;
            spawn_row   <= '0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!enable) begin
                        cooldown <= CD_RELOAD;
                    end else if (cooldown == 8'd0) begin
                        if (launch_ok) begin
                            state    <= SCAN;
                            busy     <= 1'b1;
                            slot_q   <= free_slot(bombs_active);
                            col_q    <= lfsr[CW-1:0];
                            scan_cnt <= '0;
                        end
                    end else if (frame_tick) begin
                        cooldown <= cooldown - 8'd1;
                    end
                end
                SCAN: begin
                    if (!enable) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        cooldown <= CD_RELOAD;
                    end else if (|col_bits) begin
                        state       <= OFFER;
                        spawn_valid <= 1'b1;
                        spawn_slot  <= slot_q;
                        spawn_col   <= col_q;
                        spawn_row   <= bottom_row(col_bits);
                    end else begin
                        col_q    <= col_q + CW'(1);
                        scan_cnt <= scan_cnt + (CW+1)'(1);
                        // Formation emptied mid-scan: retry as soon as possible
                        if (scan_cnt == SCAN_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                OFFER: begin
                    if (spawn_ready) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        spawn_valid <= 1'b0;
                        cooldown    <= CD_RELOAD;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alien_bomb_scheduler.sv
// Directed testbench for alien_bomb_scheduler.
module tb_alien_bomb_scheduler;

    localparam logic [39:0] ALL = {40{1'b1}};

    logic        clk;
    logic        reset;
    logic        frame_tick;
    logic        enable;
    logic [39:0] alive_matrix;
    logic [2:0]  bombs_active;
    logic        spawn_valid;
    logic        spawn_ready;
    logic [1:0]  spawn_slot;
    logic [2:0]  spawn_col;
    logic [2:0]  spawn_row;
    logic        busy;

    logic [15:0] m_lfsr;

    int checks = 0;
    int errors = 0;

    alien_bomb_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .enable       (enable),
        .alive_matrix (alive_matrix),
        .bombs_active (bombs_active),
        .spawn_valid  (spawn_valid),
        .spawn_ready  (spawn_ready),
        .spawn_slot   (spawn_slot),
        .spawn_col    (spawn_col),
        .spawn_row    (spawn_row),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference for the start-column draw
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pace(input int n, output int first, output logic [2:0] row);
        first = 0;
        row = '0;
        for (int t = 1; t <= n; t++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (spawn_valid && first == 0) begin
                    first = t;
                    row = spawn_row;
                end
            end
        end
    endtask

    initial begin
        int          first;
        logic [2:0]  row;
        logic [1:0]  ps;
        logic [2:0]  pc, pr;
        logic        stable, saw, found;
        int          lat;

        reset = 1'b1;
        frame_tick = 1'b0;
        enable = 1'b0;
        alive_matrix = '0;
        bombs_active = '0;
        spawn_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", spawn_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_payload", {spawn_slot, spawn_col, spawn_row}, 8'h00);
        check("rst_cooldown", dut.cooldown, 32'd32);

        // Cooldown pacing
        reset = 1'b0;
        enable = 1'b1;
        alive_matrix = ALL;
        spawn_ready = 1'b1;
        pace(32, first, row);
        check("pace1_tick", first, 32'd32);
        check("pace1_row", row, 3'd4);
        pace(32, first, row);
        check("pace2_tick", first, 32'd32);
        check("pace2_row", row, 3'd4);

        // Backpressure
        spawn_ready = 1'b0;
        ticks(32);
        for (int i = 0; i < 20; i++) begin
            if (spawn_valid) break;
            @(negedge clk);
        end
        check("bp_valid", spawn_valid, 1'b1);
        check("bp_row", spawn_row, 3'd4);
        ps = spawn_slot;
        pc = spawn_col;
        pr = spawn_row;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enable = ~enable;
            alive_matrix = i[0] ? ALL : 40'd0;
            @(negedge clk);
            if (!spawn_valid || spawn_slot != ps || spawn_col != pc ||
                spawn_row != pr) stable = 1'b0;
        end
        check("bp_hold", stable, 1'b1);
        enable = 1'b1;
        alive_matrix = ALL;
        spawn_ready = 1'b1;
        @(negedge clk);
        check("bp_accept", spawn_valid, 1'b0);
        check("bp_cooldown", dut.cooldown, 32'd32);

        // Slots full, then release slot 1
        bombs_active = 3'b111;
        ticks(32);
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy || spawn_valid) saw = 1'b1;
        end
        check("full_idle", saw, 1'b0);
        check("full_cooldown", dut.cooldown, 32'd0);
        bombs_active = 3'b101;
        @(negedge clk);
        @(negedge clk);
        check("free_valid", spawn_valid, 1'b1);
        check("free_slot", spawn_slot, 2'd1);
        bombs_active = 3'b000;
        @(negedge clk);

        // Column skip: only column 5 alive in row 2, start column 6
        bombs_active = 3'b111;
        alive_matrix = 40'd1 << 21;
        ticks(32);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_lfsr[2:0] == 3'd6) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("skip_seed_found", found, 1'b1);
        bombs_active = 3'b000;
        @(negedge clk);
        check("skip_busy", busy, 1'b1);
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            lat++;
            if (spawn_valid) break;
        end
        check("skip_latency", lat, 32'd8);
        check("skip_col", spawn_col, 3'd5);
        check("skip_row", spawn_row, 3'd2);
        @(negedge clk);

        // Enable low reloads the cooldown
        alive_matrix = ALL;
        ticks(27);
        check("en_cd5", dut.cooldown, 32'd5);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("en_reload", dut.cooldown, 32'd32);
        check("en_novalid", spawn_valid, 1'b0);
        enable = 1'b1;
        spawn_ready = 1'b0;
        pace(32, first, row);
        check("en_tick", first, 32'd32);
        check("en_row", row, 3'd4);

        // Reset mid-offer
        check("ro_pre_valid", spawn_valid, 1'b1);
        reset = 1'b1;
        #1;
        check("ro_valid", spawn_valid, 1'b0);
        check("ro_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ro_lfsr0", dut.u_lfsr.q, 16'hACE1);
        @(negedge clk);
        check("ro_lfsr1", dut.u_lfsr.q, 16'hE270);
        @(negedge clk);
        check("ro_lfsr2", dut.u_lfsr.q, 16'h7138);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
